// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
// Shared constants and helpers for the stopwatch display path.
//   SEG_*        : active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   IDX_*        : digit-slot index; 0 is the rightmost (Tenths) digit
//   time_digits_t: one frame's worth of BCD digits
//   pick_digit   : selects the digit shown in a given slot
// ---------------------------------------------------------------------------
package stopwatch_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] IDX_TENTHS = 2'd0;
    localparam logic [1:0] IDX_ONES   = 2'd1;
    localparam logic [1:0] IDX_TENS   = 2'd2;
    localparam logic [1:0] IDX_MIN    = 2'd3;

    typedef struct packed {
        logic [3:0] minutes;
        logic [3:0] tens;
        logic [3:0] ones;
        logic [3:0] tenths;
    } time_digits_t;

    function automatic logic [3:0] pick_digit(input time_digits_t t,
                                              input logic [1:0]   idx);
        case (idx)
            IDX_TENTHS: pick_digit = t.tenths;
            IDX_ONES:   pick_digit = t.ones;
            IDX_TENS:   pick_digit = t.tens;
            default:    pick_digit = t.minutes;
        endcase
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// ---------------------------------------------------------------------------
// bcd_to_seg
// Combinational BCD to seven-segment decoder, active-low outputs.
// Codes 10..15 are not valid BCD and show a dash so a corrupted digit is
// visible on the display instead of a misleading number.
//   i_bcd : 4-bit BCD digit
//   o_seg : segments {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module bcd_to_seg
    import stopwatch_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        // NOTE: o_seg is given a value on every path (default arm below);
        // a missing assignment in always_comb would infer a latch.
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/stopwatch_display.sv
// ---------------------------------------------------------------------------
// stopwatch_display
// Drives a 4-digit common-anode multiplexed seven-segment display in M.SS.T
// format from the stopwatch BCD digits.
//   clk, reset        : system clock; synchronous active-high reset
//   Minutes .. Tenths_Seconds : BCD digits from the stopwatch
//   hold              : keep the current snapshot (lap freeze)
//   blank_lz          : blank the Minutes digit when it is zero
//   flash             : blink the whole display
//   an                : anodes, active-low, an[0] = Tenths digit
//   seg               : segments {g,f,e,d,c,b,a}, active-low
//   dp                : decimal point, active-low
// Each digit slot lasts REFRESH_DIV cycles; the cycle after the slot tick
// has every anode off so the previous digit's pattern cannot ghost into
// the next position. The snapshot is taken once per frame, on the tick that
// returns the scan to the Tenths digit, so a frame never mixes two times.
// ---------------------------------------------------------------------------
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Minutes,
    input  logic [3:0] Tens_Seconds,
    input  logic [3:0] Ones_Seconds,
    input  logic [3:0] Tenths_Seconds,
    input  logic       hold,
    input  logic       blank_lz,
    input  logic       flash,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    time_digits_t     r_snap;
    logic [FRM_W-1:0] r_frame;
    logic             r_dark;
    logic             r_armed;   // a snapshot has been taken since reset
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    logic             w_tick;
    logic             w_wrap;
    logic             w_lit;
    logic             w_blank;
    logic [3:0]       w_digit;
    logic [6:0]       w_dec_seg;
    logic [3:0]       w_an_next;
    logic [6:0]       w_seg_next;
    logic             w_dp_next;

    assign w_tick = (r_cnt == CNT_LAST);
    assign w_wrap = w_tick && (r_idx == IDX_MIN);

    // ------------------------------------------------------------------
    // Scan counter, digit index, snapshot and blink state
    // ------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every
    // register samples the pre-edge values; reset is synchronous here,
    // so it is just the highest-priority branch inside the clocked block.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_idx   <= IDX_MIN;
            r_snap  <= '0;
            r_frame <= '0;
            r_dark  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);

            if (w_tick) begin
                r_idx <= r_idx + 2'd1;
            end

            if (w_wrap) begin
                r_armed <= 1'b1;
                if (!hold) begin
                    r_snap <= '{minutes: Minutes, tens: Tens_Seconds,
                                ones: Ones_Seconds, tenths: Tenths_Seconds};
                end
            end

            // Blink phase only runs while flash is requested; dropping
            // flash returns to the visible phase with a fresh count.
            if (!flash) begin
                r_frame <= '0;
                r_dark  <= 1'b0;
            end else if (w_wrap) begin
                if (r_frame == FRM_LAST) begin
                    r_frame <= '0;
                    r_dark  <= ~r_dark;
                end else begin
                    r_frame <= r_frame + FRM_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit selection and decode
    // ------------------------------------------------------------------
    assign w_digit = pick_digit(r_snap, r_idx);

    bcd_to_seg u_dec (
        .i_bcd (w_digit),
        .o_seg (w_dec_seg)
    );

    // The tick cycle produces the dead cycle: the index is about to move,
    // so the anodes are kept off for the following cycle.
    assign w_lit   = r_armed && !w_tick && !r_dark;
    assign w_blank = blank_lz && (r_idx == IDX_MIN) && (r_snap.minutes == 4'd0);

    always_comb begin
        w_an_next  = 4'b1111;
        w_seg_next = SEG_BLANK;
        w_dp_next  = 1'b1;
        if (w_lit) begin
            w_an_next = ~(4'b0001 << r_idx);
            if (!w_blank) begin
                w_seg_next = w_dec_seg;
                // Points sit after the minutes and after the seconds.
                w_dp_next  = !((r_idx == IDX_MIN) || (r_idx == IDX_ONES));
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_stopwatch_display.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_display
// Self-checking bench for stopwatch_display with REFRESH_DIV=4 and
// BLINK_FRAMES=2. The reference model describes the display by position in
// time: cycle n after reset sits in slot n/R, which shows digit (slot+3)%4;
// a frame starts every 4*R cycles; the blink phase is the number of frames
// seen while flashing, divided by BLINK_FRAMES, taken modulo 2.
// ---------------------------------------------------------------------------
module tb_stopwatch_display;

    localparam int R  = 4;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds;
    logic       hold, blank_lz, flash;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    stopwatch_display #(
        .REFRESH_DIV  (R),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .Minutes        (Minutes),
        .Tens_Seconds   (Tens_Seconds),
        .Ones_Seconds   (Ones_Seconds),
        .Tenths_Seconds (Tenths_Seconds),
        .hold           (hold),
        .blank_lz       (blank_lz),
        .flash          (flash),
        .an             (an),
        .seg            (seg),
        .dp             (dp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    int         n;              // cycle number since reset release
    logic [3:0] snap [4];       // 0 = tenths .. 3 = minutes
    int         flash_wraps;    // frames started while flash was held

    // Expected outputs for the current cycle
    logic       chk_en = 1'b0;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_care;       // seg/dp defined (digit lit or in reset)

    logic [3:0] nxt_an;
    logic [6:0] nxt_seg;
    logic       nxt_dp;
    logic       nxt_care;

    task automatic check(input string name, input logic [6:0] got,
                         input logic [6:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, got, want);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: ref_seg = 7'b1000000;
            4'd1: ref_seg = 7'b1111001;
            4'd2: ref_seg = 7'b0100100;
            4'd3: ref_seg = 7'b0110000;
            4'd4: ref_seg = 7'b0011001;
            4'd5: ref_seg = 7'b0010010;
            4'd6: ref_seg = 7'b0000010;
            4'd7: ref_seg = 7'b1111000;
            4'd8: ref_seg = 7'b0000000;
            4'd9: ref_seg = 7'b0010000;
            default: ref_seg = 7'b0111111;
        endcase
    endfunction

    // Predict the outputs of the next cycle from the current cycle's inputs.
    task automatic model_step();
        int idx;
        bit tick, armed, dark, lit, wrap;
        if (reset) begin
            nxt_an = 4'b1111; nxt_seg = 7'b1111111; nxt_dp = 1'b1; nxt_care = 1'b1;
            for (int i = 0; i < 4; i++) snap[i] = 4'd0;
            flash_wraps = 0;
            n = 0;
        end else begin
            idx   = ((n / R) + 3) % 4;
            tick  = (n % R) == R - 1;
            armed = n >= R;
            dark  = ((flash_wraps / BF) % 2) == 1;
            lit   = armed && !tick && !dark;
            wrap  = (n % (4 * R)) == R - 1;
            nxt_an = 4'b1111; nxt_seg = 7'b1111111; nxt_dp = 1'b1; nxt_care = lit;
            if (lit) begin
                nxt_an = ~(4'b0001 << idx);
                if (!(blank_lz && idx == 3 && snap[3] == 4'd0)) begin
                    nxt_seg = ref_seg(snap[idx]);
                    nxt_dp  = !(idx == 3 || idx == 1);
                end
            end
            if (!flash) flash_wraps = 0;
            else if (wrap) flash_wraps++;
            if (wrap && !hold) begin
                snap[0] = Tenths_Seconds;
                snap[1] = Ones_Seconds;
                snap[2] = Tens_Seconds;
                snap[3] = Minutes;
            end
            n++;
        end
    endtask

    // Apply the current inputs for one cycle; returns 1 time unit after the edge.
    task automatic drive_cycle();
        model_step();
        @(posedge clk);
        #1;
        exp_an = nxt_an; exp_seg = nxt_seg; exp_dp = nxt_dp; exp_care = nxt_care;
        chk_en = 1'b1;
    endtask

    task automatic run(input int cycles);
        repeat (cycles) drive_cycle();
    endtask

    // Single compare process against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("an", {3'b000, an}, {3'b000, exp_an});
            if (exp_care) begin
                check("seg", seg, exp_seg);
                check("dp", {6'b0, dp}, {6'b0, exp_dp});
            end
        end
    end

    initial begin
        int tries;
        reset = 1'b1; hold = 1'b0; blank_lz = 1'b0; flash = 1'b0;
        Minutes = 4'd1; Tens_Seconds = 4'd2; Ones_Seconds = 4'd3; Tenths_Seconds = 4'd4;
        run(2);
        check("reset_an", {3'b000, an}, 7'b0001111);
        check("reset_seg", seg, 7'b1111111);

        // Reset and first frame, pinned by hand-derived values
        reset = 1'b0;
        repeat (20) begin
            drive_cycle();
            case (n)
                4:  check("c4_dead_an", {3'b000, an}, 7'b0001111);
                5: begin
                    check("c5_an", {3'b000, an}, 7'b0001110);
                    check("c5_seg", seg, 7'b0011001);
                    check("c5_dp", {6'b0, dp}, 7'd1);
                end
                8:  check("c8_dead_an", {3'b000, an}, 7'b0001111);
                9: begin
                    check("c9_an", {3'b000, an}, 7'b0001101);
                    check("c9_seg", seg, 7'b0110000);
                    check("c9_dp", {6'b0, dp}, 7'd0);
                end
                13: begin
                    check("c13_an", {3'b000, an}, 7'b0001011);
                    check("c13_seg", seg, 7'b0100100);
                end
                17: begin
                    check("c17_an", {3'b000, an}, 7'b0000111);
                    check("c17_seg", seg, 7'b1111001);
                    check("c17_dp", {6'b0, dp}, 7'd0);
                end
                default: ;
            endcase
        end

        // Frame coherence: Tenths changes mid-frame, shows after the next wrap
        Tenths_Seconds = 4'd5;
        run(2);
        check("coh_old_seg", seg, 7'b0011001);
        run(15);
        check("coh_new_an", {3'b000, an}, 7'b0001110);
        check("coh_new_seg", seg, 7'b0010010);

        // Hold across three frames, then release
        hold = 1'b1;
        Minutes = 4'd9; Tens_Seconds = 4'd5; Ones_Seconds = 4'd9; Tenths_Seconds = 4'd9;
        run(48);
        hold = 1'b0;
        run(40);

        // Leading-zero blanking and an invalid Tens digit
        Minutes = 4'd0; Tens_Seconds = 4'hC; blank_lz = 1'b1;
        run(40);

        // Flash: visible/dark alternation, then drop flash while dark
        flash = 1'b1;
        run(96);
        tries = 0;
        while (((flash_wraps / BF) % 2) == 0 && tries < 64) begin
            drive_cycle();
            tries++;
        end
        run(6);
        flash = 1'b0;
        run(40);

        // Reset while the Tens digit is lit
        Minutes = 4'd7;
        tries = 0;
        while (exp_an != 4'b1011 && tries < 64) begin
            drive_cycle();
            tries++;
        end
        check("pre_reset_an", {3'b000, an}, 7'b0001011);
        reset = 1'b1;
        drive_cycle();
        check("midrst_an", {3'b000, an}, 7'b0001111);
        check("midrst_seg", seg, 7'b1111111);
        reset = 1'b0;
        run(24);

        // Randomized operation
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(3))
                    0: Tenths_Seconds = 4'($urandom_range(15));
                    1: Ones_Seconds   = 4'($urandom_range(15));
                    2: Tens_Seconds   = 4'($urandom_range(15));
                    default: Minutes  = 4'($urandom_range(2));
                endcase
            end
            if ($urandom_range(49) == 0) hold = ~hold;
            if ($urandom_range(79) == 0) flash = ~flash;
            if ($urandom_range(59) == 0) blank_lz = ~blank_lz;
            reset = ($urandom_range(399) == 0);
            drive_cycle();
        end
        reset = 1'b0;
        run(4);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
